// File: rtl/feed_ab.sv
// -----------------------------------------------------------------------------
// feed_ab
//   Read side of the per-PE ping-pong A buffer. Waits until the loader has
//   filled the current bank, pops one B operand at a time from the B FIFO
//   chain, and streams (A,B) operand pairs to the PE: for each B, all PE_NUM
//   local A elements in index order. Each popped B is forwarded to the next
//   PE's FIFO. When a whole tile of B elements is done, the bank is released
//   to the loader and the other bank becomes the read bank.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   bank_valid_in[1:0]  level: bank k filled by the loader
//   bank_free_out[1:0]  1-cycle pulse: bank k consumed, loader may refill it
//   ram_re_out          sram read enable
//   ram_raddr_out       sram read address {rd_bank, a_idx}
//   ram_rdata_in        sram read data, RD_DELAY cycles after ram_re_out
//   data_B_FIFO_in      B FIFO data, valid the cycle after RD_EN_B_FIFO_out
//   valid_B_FIFO_in     B FIFO non-empty
//   RD_EN_B_FIFO_out    B FIFO pop
//   data_B_FIFO_out     B forwarded to the next PE
//   WR_EN_B_FIFO_out    write strobe into the next PE's B FIFO
//   data_A_out          A operand to the PE
//   data_B_out          B operand to the PE
//   valid_AB_out        operand pair valid (data holds when low)
//   state_dbg           current FSM state encoding
//
// Handshake: the B FIFO pop is a valid/ready pair -- a pop happens in a cycle
//   where RD_EN_B_FIFO_out=1, which is only driven while valid_B_FIFO_in=1;
//   the popped word is presented on data_B_FIFO_in the following cycle.
//   The PE and the next-PE FIFO apply no backpressure.
// -----------------------------------------------------------------------------
module feed_ab #(
  parameter int D_WIDTH      = 64,
  parameter int PE_NUM_WIDTH = 1,
  parameter int PE_NUM       = 2,
  parameter int B_NUM_WIDTH  = 1,
  parameter int RD_DELAY     = 2,
  parameter int LAST_PE      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              bank_valid_in,
  output logic [1:0]              bank_free_out,
  output logic                    ram_re_out,
  output logic [PE_NUM_WIDTH:0]   ram_raddr_out,
  input  logic [D_WIDTH-1:0]      ram_rdata_in,
  input  logic [D_WIDTH-1:0]      data_B_FIFO_in,
  input  logic                    valid_B_FIFO_in,
  output logic                    RD_EN_B_FIFO_out,
  output logic [D_WIDTH-1:0]      data_B_FIFO_out,
  output logic                    WR_EN_B_FIFO_out,
  output logic [D_WIDTH-1:0]      data_A_out,
  output logic [D_WIDTH-1:0]      data_B_out,
  output logic                    valid_AB_out,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_B = 3'd1,
    LATCH  = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam int DCW = (RD_DELAY > 1) ? $clog2(RD_DELAY) : 1;
  localparam logic [PE_NUM_WIDTH-1:0] A_LAST     = PE_NUM_WIDTH'(PE_NUM - 1);
  localparam logic [DCW-1:0]          DRAIN_LAST = DCW'(RD_DELAY - 1);
  localparam logic                    FWD_EN     = (LAST_PE == 0);

  state_t                  state;
  logic                    rd_bank;
  logic [PE_NUM_WIDTH-1:0] a_idx;
  logic [B_NUM_WIDTH-1:0]  b_cnt;
  logic [DCW-1:0]          drain_cnt;
  logic [D_WIDTH-1:0]      b_reg;

  // re and the B operand travel together so B lines up with sram data.
  logic [RD_DELAY-1:0]     re_pipe;
  logic [D_WIDTH-1:0]      b_pipe [RD_DELAY];

  assign state_dbg        = state;
  assign RD_EN_B_FIFO_out = (state == WAIT_B) && valid_B_FIFO_in;
  assign ram_re_out       = (state == STREAM);
  assign ram_raddr_out    = {rd_bank, a_idx};

  // Forward happens in the cycle the popped word is on the FIFO data bus.
  assign WR_EN_B_FIFO_out = FWD_EN && (state == LATCH);
  assign data_B_FIFO_out  = WR_EN_B_FIFO_out ? data_B_FIFO_in : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_bank       <= 1'b0;
      a_idx         <= '0;
      b_cnt         <= '0;
      drain_cnt     <= '0;
      b_reg         <= '0;
      bank_free_out <= 2'b00;
    end else begin
      bank_free_out <= 2'b00;
      case (state)
        IDLE: begin
          // Only the current read bank matters; the other waits its turn.
          if (bank_valid_in[rd_bank]) state <= WAIT_B;
        end
        WAIT_B: begin
          if (valid_B_FIFO_in) state <= LATCH;
        end
        LATCH: begin
          b_reg <= data_B_FIFO_in;
          state <= STREAM;
        end
        STREAM: begin
          if (a_idx == A_LAST) begin
            a_idx <= '0;
            if (b_cnt == '1) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              b_cnt <= b_cnt + 1'b1;
              state <= WAIT_B;
            end
          end else begin
            a_idx <= a_idx + 1'b1;
          end
        end
        DRAIN: begin
          // Hold the bank until the last read has returned from the sram.
          if (drain_cnt == DRAIN_LAST) begin
            bank_free_out <= rd_bank ? 2'b10 : 2'b01;
            rd_bank       <= ~rd_bank;
            b_cnt         <= '0;
            state         <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_pipe      <= '0;
      for (int i = 0; i < RD_DELAY; i++) b_pipe[i] <= '0;
      valid_AB_out <= 1'b0;
      data_A_out   <= '0;
      data_B_out   <= '0;
    end else begin
      re_pipe[0] <= ram_re_out;
      b_pipe[0]  <= b_reg;
      for (int i = 1; i < RD_DELAY; i++) begin
        re_pipe[i] <= re_pipe[i-1];
        b_pipe[i]  <= b_pipe[i-1];
      end
      valid_AB_out <= re_pipe[RD_DELAY-1];
      if (re_pipe[RD_DELAY-1]) begin
        data_A_out <= ram_rdata_in;
        data_B_out <= b_pipe[RD_DELAY-1];
      end
    end
  end

endmodule

// File: tb/tb_feed_ab.sv
`timescale 1ns/1ps
module tb_feed_ab;

  localparam int D  = 64;
  localparam int PW = 1;
  localparam int PN = 2;
  localparam int BW = 1;
  localparam int RD = 2;
  localparam int BN = 1 << BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    bank_valid_in = 2'b00;
  logic [1:0]    bank_free_out;
  logic          ram_re_out;
  logic [PW:0]   ram_raddr_out;
  logic [D-1:0]  ram_rdata_in = '0;
  logic [D-1:0]  data_B_FIFO_in = '0;
  logic          valid_B_FIFO_in = 1'b0;
  logic          RD_EN_B_FIFO_out;
  logic [D-1:0]  data_B_FIFO_out;
  logic          WR_EN_B_FIFO_out;
  logic [D-1:0]  data_A_out;
  logic [D-1:0]  data_B_out;
  logic          valid_AB_out;
  logic [2:0]    state_dbg;

  // LAST_PE instance shares all inputs; only its forward port is observed.
  logic [1:0]    l_bank_free;
  logic          l_re;
  logic [PW:0]   l_raddr;
  logic          l_rd_en;
  logic [D-1:0]  l_fwd_data;
  logic          l_wr_en;
  logic [D-1:0]  l_a;
  logic [D-1:0]  l_b;
  logic          l_valid;
  logic [2:0]    l_state;

  feed_ab #(.D_WIDTH(D), .PE_NUM_WIDTH(PW), .PE_NUM(PN), .B_NUM_WIDTH(BW),
            .RD_DELAY(RD), .LAST_PE(0)) dut (
    .clk(clk), .rst_n(rst_n), .bank_valid_in(bank_valid_in),
    .bank_free_out(bank_free_out), .ram_re_out(ram_re_out),
    .ram_raddr_out(ram_raddr_out), .ram_rdata_in(ram_rdata_in),
    .data_B_FIFO_in(data_B_FIFO_in), .valid_B_FIFO_in(valid_B_FIFO_in),
    .RD_EN_B_FIFO_out(RD_EN_B_FIFO_out), .data_B_FIFO_out(data_B_FIFO_out),
    .WR_EN_B_FIFO_out(WR_EN_B_FIFO_out), .data_A_out(data_A_out),
    .data_B_out(data_B_out), .valid_AB_out(valid_AB_out), .state_dbg(state_dbg)
  );

  feed_ab #(.D_WIDTH(D), .PE_NUM_WIDTH(PW), .PE_NUM(PN), .B_NUM_WIDTH(BW),
            .RD_DELAY(RD), .LAST_PE(1)) u_last (
    .clk(clk), .rst_n(rst_n), .bank_valid_in(bank_valid_in),
    .bank_free_out(l_bank_free), .ram_re_out(l_re),
    .ram_raddr_out(l_raddr), .ram_rdata_in(ram_rdata_in),
    .data_B_FIFO_in(data_B_FIFO_in), .valid_B_FIFO_in(valid_B_FIFO_in),
    .RD_EN_B_FIFO_out(l_rd_en), .data_B_FIFO_out(l_fwd_data),
    .WR_EN_B_FIFO_out(l_wr_en), .data_A_out(l_a),
    .data_B_out(l_b), .valid_AB_out(l_valid), .state_dbg(l_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pop_cnt = 0;
  int tiles_done = 0;
  int last_fwd = 0;
  int b_seq = 0;
  logic b_gate = 1'b1;
  logic rand_gate = 1'b0;
  logic cur_bank = 1'b0;
  int re_idx = 0;

  logic [2*D-1:0] exp_q[$];      // expected {A,B} pairs in order
  logic [D-1:0]   exp_fwd_q[$];  // expected forwarded B values
  logic [D-1:0]   bq[$];         // upstream B FIFO contents
  logic [D-1:0]   mem [2][PN];   // A buffer contents per bank
  logic [D-1:0]   rd_p1 = '0;

  task automatic chk(input string tag, input logic [2*D-1:0] obs, input logic [2*D-1:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sram model: data returns RD cycles after the read enable.
  always @(posedge clk) begin
    rd_p1        <= ram_re_out ? mem[ram_raddr_out[PW]][ram_raddr_out[PW-1:0]] : '0;
    ram_rdata_in <= rd_p1;
  end

  // Upstream B FIFO model.
  always @(posedge clk) begin
    if (!rst_n) begin
      bq.delete();
      valid_B_FIFO_in <= 1'b0;
      data_B_FIFO_in  <= '0;
    end else begin
      if (RD_EN_B_FIFO_out) begin
        pop_cnt++;
        if (bq.size() > 0) data_B_FIFO_in <= bq.pop_front();
      end
      valid_B_FIFO_in <= b_gate && (bq.size() > 0) &&
                         (!rand_gate || ($urandom_range(0, 1) == 1));
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_fwd_q.delete();
      cur_bank = 1'b0;
      re_idx   = 0;
    end else begin
      if (valid_AB_out) begin
        chk("pair_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("pair", {data_A_out, data_B_out}, exp_q.pop_front());
      end
      if (WR_EN_B_FIFO_out) begin
        chk("fwd_expected", (exp_fwd_q.size() != 0), 1);
        if (exp_fwd_q.size() != 0) chk("fwd_data", data_B_FIFO_out, exp_fwd_q.pop_front());
      end
      if (ram_re_out) begin
        chk("raddr", ram_raddr_out, {cur_bank, PW'(re_idx)});
        re_idx = (re_idx == PN - 1) ? 0 : re_idx + 1;
      end
      if (bank_free_out != 2'b00) begin
        chk("bank_free", bank_free_out, cur_bank ? 2'b10 : 2'b01);
        bank_valid_in = bank_valid_in & ~bank_free_out;
        cur_bank = ~cur_bank;
        tiles_done++;
      end
      if (l_wr_en) last_fwd++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input int k, input logic set_valid);
    for (int i = 0; i < PN; i++) mem[k][i] = {$urandom, $urandom};
    if (set_valid) bank_valid_in[k] = 1'b1;
  endtask

  // Each B of a tile yields one pair per local A element, in index order;
  // tiles alternate banks starting from bank 0 after reset.
  task automatic push_b(input logic [D-1:0] b);
    int bnk;
    bnk = (b_seq / BN) % 2;
    for (int i = 0; i < PN; i++) exp_q.push_back({mem[bnk][i], b});
    exp_fwd_q.push_back(b);
    bq.push_back(b);
    b_seq++;
  endtask

  task automatic wait_tiles(input int n);
    int target;
    target = tiles_done + n;
    for (int i = 0; i < 400 && tiles_done < target; i++) step();
    chk("tile_timeout", (tiles_done >= target), 1);
  endtask

  function automatic logic [D-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int t_pop;
    int t_val;
    int p0;
    int p1;
    logic [D-1:0] b0;
    logic       seen;

    t_pop = 0; t_val = 0; p0 = 0; p1 = 0; b0 = '0; seen = 1'b0;
    repeat (3) step();
    chk("reset_outs", {bank_free_out, ram_re_out, ram_raddr_out, RD_EN_B_FIFO_out,
                       WR_EN_B_FIFO_out, valid_AB_out, state_dbg}, 0);
    chk("reset_data", {data_A_out, data_B_out}, 0);
    rst_n = 1'b1;
    step();

    // No filled bank: B available but nothing is popped or read.
    load_bank(0, 1'b0);
    push_b(rnd64());
    push_b(rnd64());
    seen = 1'b0;
    repeat (20) begin
      step();
      if (RD_EN_B_FIFO_out || ram_re_out) seen = 1'b1;
    end
    chk("idle_no_activity", seen, 0);
    chk("idle_no_pop", pop_cnt, 0);

    // Bank 0 tile: latency from first pop to first valid pair.
    p0 = pop_cnt;
    bank_valid_in[0] = 1'b1;
    for (int i = 0; i < 50 && !RD_EN_B_FIFO_out; i++) step();
    chk("first_pop_seen", RD_EN_B_FIFO_out, 1);
    t_pop = cyc;
    for (int i = 0; i < 50 && !valid_AB_out; i++) step();
    chk("first_valid_seen", valid_AB_out, 1);
    t_val = cyc;
    chk("first_latency", t_val - t_pop, 3 + RD);
    wait_tiles(1);
    chk("pops_tile0", pop_cnt - p0, BN);

    // Bank 1 tile with the second B withheld for a while.
    load_bank(1, 1'b1);
    b0 = rnd64();
    p0 = pop_cnt;
    push_b(b0);
    for (int i = 0; i < 50 && pop_cnt == p0; i++) step();
    chk("gap_first_pop", pop_cnt - p0, 1);
    b_gate = 1'b0;
    push_b(rnd64());
    p1 = pop_cnt;
    repeat (12) step();
    chk("gap_no_pop", pop_cnt, p1);
    chk("gap_valid_low", valid_AB_out, 0);
    chk("gap_hold_a", data_A_out, mem[1][PN-1]);
    chk("gap_hold_b", data_B_out, b0);
    b_gate = 1'b1;
    wait_tiles(1);

    // Both banks filled back to back.
    load_bank(0, 1'b1);
    load_bank(1, 1'b1);
    repeat (2 * BN) push_b(rnd64());
    wait_tiles(2);

    // Reset in the middle of a tile.
    load_bank(0, 1'b1);
    push_b(rnd64());
    push_b(rnd64());
    for (int i = 0; i < 50 && !valid_AB_out; i++) step();
    chk("pre_reset_valid", valid_AB_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {bank_free_out, ram_re_out, ram_raddr_out, RD_EN_B_FIFO_out,
                        WR_EN_B_FIFO_out, valid_AB_out, state_dbg}, 0);
    chk("midrst_data", {data_A_out, data_B_out, data_B_FIFO_out}, 0);
    bank_valid_in = 2'b00;
    b_seq = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    // Both banks offered: the first tile after reset must come from bank 0.
    load_bank(0, 1'b1);
    load_bank(1, 1'b1);
    push_b(rnd64());
    push_b(rnd64());
    wait_tiles(1);

    // Randomized tiles with random B availability.
    rand_gate = 1'b1;
    repeat (6) begin
      load_bank((b_seq / BN) % 2, 1'b1);
      repeat (BN) push_b(rnd64());
      wait_tiles(1);
    end
    rand_gate = 1'b0;
    repeat (10) step();

    chk("pairs_drained", exp_q.size(), 0);
    chk("fwd_drained", exp_fwd_q.size(), 0);
    chk("last_pe_no_fwd", last_fwd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
